// File: rtl/phy_pkg.sv
// Shared PHY receive-path definitions: idle symbol, lock depth, lane FSM states.
package phy_pkg;

  localparam logic [7:0]  COM_SYM        = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/sp_align_lane_if.sv
// Lane-side signals of the receive deserializer: serial input and byte output.
interface sp_align_lane_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;

  // Deserializer side
  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output active_out
  );

  // Serial source / byte consumer side
  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active_out
  );

endinterface

// File: rtl/sp_shift8.sv
// Serial-to-parallel front end: shift register plus free-running bit counter.
module sp_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       clr,
  output logic [7:0] nb,
  output logic       boundary
);

  // Only the seven most recent bits are stored; the eighth is data_in itself.
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q;

  assign nb       = {sr_q, data_in};
  assign boundary = (bit_cnt_q == 3'd7);

  // Shift in one bit per edge; clr realigns the byte phase to the current edge.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= nb[6:0];
      bit_cnt_q <= clr ? 3'd0 : bit_cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/sp_align_lane.sv
// Per-lane receive deserializer: hunts for COM, locks after a run of aligned COMs,
// then strobes out every non-COM byte.
module sp_align_lane
  import phy_pkg::*;
#(
  parameter logic [7:0]  COM        = COM_SYM,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic           clk_32f,
  input  logic           reset,
  sp_align_lane_if.master lane
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  state_e     state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [3:0] com_inc;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] nb;
  logic       boundary;
  logic       clr;
  logic       is_com;

  sp_shift8 u_shift8 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (lane.data_in),
    .clr      (clr),
    .nb       (nb),
    .boundary (boundary)
  );

  assign is_com  = (nb == COM);
  assign com_inc = (com_cnt_q == 4'hF) ? com_cnt_q : com_cnt_q + 4'd1;

  // Alignment FSM next state, COM run counter and output register next values.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    clr       = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        // Any bit position may start a byte; a hit fixes the byte phase.
        if (is_com) begin
          clr       = 1'b1;
          com_cnt_d = 4'd1;
          state_d   = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == LockCnt) begin
              state_d  = ST_LOCKED;
              active_d = 1'b1;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = ST_SEARCH;
          end
        end
      end
      ST_LOCKED: begin
        // COM is idle fill and is never delivered.
        if (boundary && !is_com) begin
          data_d  = nb;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // State and output registers; reset overrides everything on its edge.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      com_cnt_q <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign lane.data_out   = data_q;
  assign lane.valid_out  = valid_q;
  assign lane.active_out = active_q;

endmodule

// File: tb/tb_sp_align_lane.sv
// Self-checking bench for sp_align_lane: directed plan steps plus random traffic,
// every cycle compared against a bit-history reference model.
module tb_sp_align_lane;

  localparam logic [7:0] ComByte = 8'hBC;
  localparam int         LockN   = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  sp_align_lane_if lane ();

  sp_align_lane #(
    .COM        (ComByte),
    .LOCK_COUNT (LockN)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: recent bit history plus a hunting/counting/locked mode.
  logic       hist[$];
  int         m_mode;   // 0 hunting, 1 counting COM run, 2 locked
  int         m_since;  // bits received since the aligning COM
  int         m_run;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_active;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         rise_cyc    = 0;
  int         strobe_t[$];
  logic [7:0] strobe_d[$];

  function automatic logic [7:0] window();
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = hist.size() - 8 + i;
      w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_edge(input logic b, input logic r);
    logic [7:0] w;
    if (r) begin
      hist.delete();
      m_mode     = 0;
      m_since    = 0;
      m_run      = 0;
      exp_data   = 8'h00;
      exp_valid  = 1'b0;
      exp_active = 1'b0;
    end else begin
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
      w = window();
      exp_valid = 1'b0;
      case (m_mode)
        0: begin
          if (w == ComByte) begin
            m_mode  = 1;
            m_run   = 1;
            m_since = 0;
          end
        end
        1: begin
          m_since++;
          if (m_since % 8 == 0) begin
            if (w == ComByte) begin
              m_run++;
              if (m_run == LockN) begin
                m_mode     = 2;
                exp_active = 1'b1;
              end
            end else begin
              m_mode = 0;
              m_run  = 0;
            end
          end
        end
        default: begin
          m_since++;
          if (m_since % 8 == 0 && w != ComByte) begin
            exp_data  = w;
            exp_valid = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One bit-clock cycle: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic b, input logic r);
    lane.data_in = b;
    reset        = r;
    @(posedge clk_32f);
    cyc++;
    model_edge(b, r);
    #1;
    check("data_out", lane.data_out, exp_data);
    check("valid_out", {7'b0, lane.valid_out}, {7'b0, exp_valid});
    check("active_out", {7'b0, lane.active_out}, {7'b0, exp_active});
    if (lane.valid_out === 1'b1) begin
      strobe_t.push_back(cyc);
      strobe_d.push_back(lane.data_out);
    end
    if (lane.active_out === 1'b1 && rise_cyc == 0) rise_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b1);
    cyc      = 0;
    rise_cyc = 0;
    strobe_t.delete();
    strobe_d.delete();
  endtask

  initial begin
    logic [7:0] rb;
    lane.data_in = 1'b0;

    // 1: reset with random line activity
    do_reset(3);
    check("rst_data", lane.data_out, 8'h00);
    check("rst_active", {7'b0, lane.active_out}, 8'h00);

    // 2: clean lock from bit 0
    for (int k = 0; k < 4; k++) send_byte(ComByte);
    check_int("t2_rise_cycle", rise_cyc, 32);
    check_int("t2_no_strobes", strobe_t.size(), 0);

    // 3: misaligned lock, then data between idles
    do_reset(2);
    for (int k = 0; k < 3; k++) step(1'($urandom), 1'b0);
    for (int k = 0; k < 5; k++) send_byte(ComByte);
    check_int("t3_rise_cycle", rise_cyc, 35);
    send_byte(ComByte);
    send_byte(8'h5A);
    send_byte(ComByte);
    send_byte(8'hC3);
    check_int("t3_strobe_count", strobe_t.size(), 2);
    if (strobe_t.size() >= 2) begin
      check("t3_first", strobe_d[0], 8'h5A);
      check("t3_second", strobe_d[1], 8'hC3);
      check_int("t3_spacing", strobe_t[1] - strobe_t[0], 16);
    end

    // 4: broken COM run
    do_reset(2);
    for (int k = 0; k < 3; k++) send_byte(ComByte);
    send_byte(8'h11);
    for (int k = 0; k < 4; k++) send_byte(ComByte);
    check_int("t4_rise_cycle", rise_cyc, 64);

    // 5: back-to-back data
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hFF);
    check_int("t5_strobe_count", strobe_t.size(), 4);
    if (strobe_t.size() >= 4) begin
      check("t5_d0", strobe_d[0], 8'h01);
      check("t5_d1", strobe_d[1], 8'h02);
      check("t5_d2", strobe_d[2], 8'h03);
      check("t5_d3", strobe_d[3], 8'hFF);
      for (int k = 1; k < 4; k++) check_int("t5_spacing", strobe_t[k] - strobe_t[k-1], 8);
    end

    // 6: reset in mid-byte while locked, then full relock
    for (int k = 0; k < 4; k++) step(1'($urandom), 1'b0);
    step(1'($urandom), 1'b1);
    check("t6_active_drop", {7'b0, lane.active_out}, 8'h00);
    check("t6_valid_drop", {7'b0, lane.valid_out}, 8'h00);
    cyc      = 0;
    rise_cyc = 0;
    for (int k = 0; k < 3; k++) send_byte(ComByte);
    check("t6_not_yet", {7'b0, lane.active_out}, 8'h00);
    send_byte(ComByte);
    check("t6_relocked", {7'b0, lane.active_out}, 8'h01);
    check_int("t6_rise_cycle", rise_cyc, 32);

    // Random locked traffic with roughly one idle in four
    strobe_t.delete();
    strobe_d.delete();
    for (int k = 0; k < 40; k++) begin
      rb = ($urandom_range(0, 3) == 0) ? ComByte : 8'($urandom);
      send_byte(rb);
    end
    for (int k = 1; k < strobe_t.size(); k++) begin
      if (strobe_t[k] - strobe_t[k-1] < 8) check_int("rand_min_gap", strobe_t[k] - strobe_t[k-1], 8);
    end

    // Random pre-lock noise (false COM hits), then lock and random data
    do_reset(2);
    for (int k = 0; k < 300; k++) step(1'($urandom), 1'b0);
    for (int k = 0; k < 5; k++) send_byte(ComByte);
    for (int k = 0; k < 20; k++) send_byte(8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_align_lane.md
# sp_align_lane

Per-lane receive deserializer for the PHY receive path, the receive-side counterpart of the lane serializer. It samples one serial lane at the bit clock, finds byte alignment by hunting for the COM idle symbol, and declares the lane active after a run of aligned COM bytes. It then emits each non-COM byte as an 8-bit word with a one-cycle valid strobe. One instance sits per lane, ahead of the byte-to-word packing and un-striping stages.

## Interface
- `COM`, default `8'hBC`: idle/alignment symbol; the transmitter sends it whenever it has no valid data.
- `LOCK_COUNT`, default `4`: number of consecutive aligned COM bytes needed to lock. Legal range 2..15.

Ports:
- `clk_32f`, input, 1 bit: bit clock. Everything updates on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `data_in`, input, 1 bit: serial lane, MSB of each byte first.
- `data_out`, output, 8 bits: received data byte, registered.
- `valid_out`, output, 1 bit: one-cycle strobe marking a new `data_out`.
- `active_out`, output, 1 bit: lane locked. Feeds the upstream `active_lane` logic.

## Operation
- Shift register: every edge, `sr <= {sr[6:0], data_in}`. The candidate byte is `nb = {sr[6:0], data_in}`.
- `bit_cnt`, 3 bits, wraps 7 to 0. An edge where `bit_cnt == 7` is a byte boundary, and `nb` is the completed byte.
- States:
  - **SEARCH**: every edge, compare `nb` with `COM`. On a match: `bit_cnt <= 0`, `com_cnt <= 1`, go to ALIGN. Otherwise stay.
  - **ALIGN**: at each byte boundary:
    - `nb == COM`: `com_cnt++`. When the incremented value equals `LOCK_COUNT`, go to LOCKED and set `active_out <= 1`.
    - `nb != COM`: `com_cnt <= 0`, go to SEARCH. Hunting resumes on the next edge, not at this byte.
- **LOCKED**: at each byte boundary:
  - `nb == COM`: idle, `valid_out <= 0`, `data_out` holds.
  - `nb != COM`: `data_out <= nb`, `valid_out <= 1`.
  - On all other edges `valid_out <= 0`.
  - LOCKED is left only by `reset`.
- `valid_out` and `data_out` never change outside LOCKED.
- `com_cnt` is 4 bits and saturates; it is not incremented once LOCKED.

## Timing
Reset values, applied at the first rising edge with `reset == 1`:
- `sr = 0`, `bit_cnt = 0`, `com_cnt = 0`, state SEARCH.
- `data_out = 8'h00`, `valid_out = 0`, `active_out = 0`.

Reset behaviour:
- `reset` dominates all other conditions on that edge.
- Reset asserted mid-operation (including while LOCKED) drops `active_out` and `valid_out` on the next edge.

Alignment and latency:
- The earliest match is after 8 sampled bits. With `LOCK_COUNT=4`, `active_out` rises on the edge that samples bit 32 of a clean COM stream aligned from bit 0. It is visible in the following cycle.
- Data latency: the LSB of a byte is sampled on edge N; `data_out` and `valid_out` are valid from edge N until edge N+1.
- `valid_out` is high for at most 1 of every 8 cycles.
- Back-to-back data bytes produce strobes exactly 8 cycles apart.

Corner cases:
- A byte equal to `COM` while LOCKED is always treated as idle; it is never delivered as data.
- A false COM match inside random pre-lock data enters ALIGN. A following non-COM byte returns the block to SEARCH with no output.

## Structure
- Shared package `phy_pkg` holds:
  - `COM_SYM = 8'hBC`;
  - the state enum `{ST_SEARCH, ST_ALIGN, ST_LOCKED}` with 2-bit encoding 0, 1, 2;
  - `LOCK_COUNT_DEF = 4`.
- One natural sub-module, `sp_shift8`. It contains the shift register and the 3-bit bit counter with synchronous clear. It outputs `nb` and `boundary`.
- The top level holds the FSM, `com_cnt`, and the output registers.

## Test plan
1. **Reset:** hold `reset` 3 cycles while driving random `data_in` → `data_out = 00`, `valid_out = 0`, `active_out = 0` throughout.
2. **Clean lock:** send 4×`BC` from bit 0 → `active_out` rises one cycle after bit 32. No `valid_out` during the lock sequence.
3. **Misaligned lock:** send 3 random bits, then 5×`BC` → lock happens after the 4th full `BC` that follows the first match. Continue with `BC 5A BC C3` → strobes carry `5A` and `C3`, 16 cycles apart.
4. **Broken run:** send `BC BC BC 11 BC BC BC BC` → returns to SEARCH at `11` and locks only on the final 4 `BC`.
5. **Back-to-back data:** after lock, send `01 02 03 FF` → four strobes spaced exactly 8 cycles apart, with `data_out` equal to 01, 02, 03, FF.
6. **Reset while locked:** assert `reset` in the middle of a data byte → next cycle `active_out = 0`, `valid_out = 0`. A relock needs the full 4×`BC` again.
